// File: rtl/load_store_unit_if.sv
// Request/response and data_mem pin bundle for the load/store unit.
// master: pipeline + memory side; slave: load_store_unit.
//   req_*  : valid/ready request (we, funct3, byte addr, store data)
//   rsp_*  : one-cycle completion strobe with extended data and error flag
//   mem_*  : data_mem A/WD/WE/WM outputs and RD input
interface load_store_unit_if #(
    parameter int ADDR_W = 10
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wd;
    logic              mem_we;
    logic [3:0]        mem_wm;
    logic [31:0]       mem_rd;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  mem_addr, mem_wd, mem_we, mem_wm
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output mem_addr, mem_wd, mem_we, mem_wm
    );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit driving a byte-lane data_mem (one lane per write).
// Ports: i_clk, i_rst (sync, active-high), bus (load_store_unit_if.slave).
// Option: MISALIGN_SPLIT_EN enables word-crossing LH/LHU/SH/LW/SW;
//   when undefined, such accesses complete with rsp_err and no access.
module load_store_unit #(
    parameter int ADDR_W = 10
) (
    input  logic             i_clk,
    input  logic             i_rst,
    load_store_unit_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_LOAD2, S_STORE, S_RESP
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_word;
    logic [1:0]        r_off;
    logic [2:0]        r_f3;
    logic [7:0]        r_mask;
    logic              r_split;
    logic [31:0]       r_lo;

    logic [ADDR_W-1:0] w_word;
    logic [1:0]        w_off;
    logic [2:0]        w_f3;
    logic [7:0]        w_base;
    logic [7:0]        w_req_mask;
    logic              w_illegal;
    logic              w_misal;
    logic              w_err;
    logic [7:0]        w_lane_src;
    logic [7:0]        w_lane;
    logic [3:0]        w_lane_wm;
    logic              w_lane_hi;
    logic [ADDR_W-1:0] w_word_src;
    logic [63:0]       w_rot64;
    logic [31:0]       w_ld_lo;
    logic [31:0]       w_ld_hi;
    logic [63:0]       w_sh64;
    logic [31:0]       w_sh;
    logic [31:0]       w_ext;
    logic              w_unused_ok;

    assign w_word = bus.req_addr[ADDR_W+1:2];
    assign w_off  = bus.req_addr[1:0];
    assign w_f3   = bus.req_funct3;
    assign w_unused_ok = ^bus.req_addr[31:ADDR_W+2];

    always_comb begin
        w_base = 8'h0F;
        unique case (w_f3[1:0])
            2'b00:   w_base = 8'h01;
            2'b01:   w_base = 8'h03;
            default: w_base = 8'h0F;
        endcase
    end

    // Bits [3:0] address word, bits [7:4] address word+1.
    assign w_req_mask = w_base << w_off;

    assign w_illegal = (w_f3 == 3'b011) || (w_f3 == 3'b110) ||
                       (w_f3 == 3'b111) || (bus.req_we && w_f3[2]);
`ifdef MISALIGN_SPLIT_EN
    assign w_misal = 1'b0;
`else
    assign w_misal = ((w_f3[1:0] == 2'b01) && w_off[0]) ||
                     ((w_f3[1:0] == 2'b10) && (w_off != 2'b00));
`endif
    assign w_err = w_illegal || w_misal;

    // Next store lane: lowest set bit of the remaining mask, so word
    // lanes go out before word+1 lanes.
    assign w_lane_src = (r_state == S_IDLE) ? w_req_mask : r_mask;
    assign w_lane     = w_lane_src & (~w_lane_src + 8'd1);
    assign w_lane_wm  = w_lane[3:0] | w_lane[7:4];
    assign w_lane_hi  = (w_lane[3:0] == 4'd0);
    assign w_word_src = (r_state == S_IDLE) ? w_word : r_word;

    // Rotate left by 8*off: store byte k lands in lane (off+k)%4.
    assign w_rot64 = {bus.req_wdata, bus.req_wdata} << {w_off, 3'b000};

    assign w_ld_lo = (r_state == S_LOAD) ? bus.mem_rd : r_lo;
    assign w_ld_hi = (r_state == S_LOAD2) ? bus.mem_rd : 32'd0;
    assign w_sh64  = {w_ld_hi, w_ld_lo} >> {r_off, 3'b000};
    assign w_sh    = w_sh64[31:0];

    always_comb begin
        w_ext = w_sh;
        unique case (r_f3)
            3'b000:  w_ext = {{24{w_sh[7]}}, w_sh[7:0]};
            3'b001:  w_ext = {{16{w_sh[15]}}, w_sh[15:0]};
            3'b100:  w_ext = {24'd0, w_sh[7:0]};
            3'b101:  w_ext = {16'd0, w_sh[15:0]};
            default: w_ext = w_sh;
        endcase
    end

    assign bus.req_ready = (r_state == S_IDLE);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= S_IDLE;
            r_word        <= '0;
            r_off         <= 2'd0;
            r_f3          <= 3'd0;
            r_mask        <= 8'd0;
            r_split       <= 1'b0;
            r_lo          <= 32'd0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= 32'd0;
            bus.rsp_err   <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wd    <= 32'd0;
            bus.mem_we    <= 1'b0;
            bus.mem_wm    <= 4'd0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        r_word <= w_word;
                        r_off  <= w_off;
                        r_f3   <= w_f3;
                        if (w_err) begin
                            r_state       <= S_RESP;
                            bus.rsp_valid <= 1'b1;
                            bus.rsp_err   <= 1'b1;
                            bus.rsp_rdata <= 32'd0;
                        end else if (bus.req_we) begin
                            r_state      <= S_STORE;
                            r_mask       <= w_lane_src & ~w_lane;
                            bus.mem_we   <= 1'b1;
                            bus.mem_wm   <= w_lane_wm;
                            bus.mem_wd   <= w_rot64[63:32];
                            bus.mem_addr <= w_lane_hi ?
                                w_word_src + ADDR_W'(1) : w_word_src;
                        end else begin
                            r_state      <= S_LOAD;
                            r_split      <= (w_req_mask[7:4] != 4'd0);
                            bus.mem_addr <= w_word;
                        end
                    end
                end
                S_STORE: begin
                    if (r_mask != 8'd0) begin
                        r_mask       <= w_lane_src & ~w_lane;
                        bus.mem_wm   <= w_lane_wm;
                        bus.mem_addr <= w_lane_hi ?
                            w_word_src + ADDR_W'(1) : w_word_src;
                    end else begin
                        r_state       <= S_RESP;
                        bus.mem_we    <= 1'b0;
                        bus.mem_wm    <= 4'd0;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_err   <= 1'b0;
                        bus.rsp_rdata <= 32'd0;
                    end
                end
                S_LOAD: begin
                    r_lo <= bus.mem_rd;
                    if (r_split) begin
                        r_state      <= S_LOAD2;
                        bus.mem_addr <= r_word + ADDR_W'(1);
                    end else begin
                        r_state       <= S_RESP;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_err   <= 1'b0;
                        bus.rsp_rdata <= w_ext;
                    end
                end
                S_LOAD2: begin
                    r_state       <= S_RESP;
                    bus.rsp_valid <= 1'b1;
                    bus.rsp_err   <= 1'b0;
                    bus.rsp_rdata <= w_ext;
                end
                S_RESP: begin
                    r_state       <= S_IDLE;
                    bus.rsp_valid <= 1'b0;
                    bus.rsp_err   <= 1'b0;
                    bus.rsp_rdata <= 32'd0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a byte-lane data_mem model.
// Honours MISALIGN_SPLIT_EN for the word-crossing load scenario.
module tb_load_store_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    load_store_unit_if #(.ADDR_W(10)) bus ();

    load_store_unit #(.ADDR_W(10)) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus.slave)
    );

    logic [31:0] mem [0:1023];
    assign bus.mem_rd = mem[bus.mem_addr];

    // data_mem commits only the lowest set WM lane per cycle.
    always @(posedge clk) begin
        if (bus.mem_we) begin
            if (bus.mem_wm[0])      mem[bus.mem_addr][7:0]   <= bus.mem_wd[7:0];
            else if (bus.mem_wm[1]) mem[bus.mem_addr][15:8]  <= bus.mem_wd[15:8];
            else if (bus.mem_wm[2]) mem[bus.mem_addr][23:16] <= bus.mem_wd[23:16];
            else if (bus.mem_wm[3]) mem[bus.mem_addr][31:24] <= bus.mem_wd[31:24];
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    logic [3:0]  l_wm   [1:8];
    logic        l_we   [1:8];
    logic [9:0]  l_addr [1:8];
    logic [31:0] l_wd   [1:8];
    int          lat;
    int          nrsp;
    logic [31:0] r_rd;
    logic        r_er;
    int          any_we;

    task automatic run(input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        lat = 0; nrsp = 0; any_we = 0; r_rd = 32'd0; r_er = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            l_wm[k]   = bus.mem_wm;
            l_we[k]   = bus.mem_we;
            l_addr[k] = bus.mem_addr;
            l_wd[k]   = bus.mem_wd;
            if (bus.mem_we) any_we++;
            if (bus.rsp_valid) begin
                nrsp++;
                if (lat == 0) begin
                    lat  = k;
                    r_rd = bus.rsp_rdata;
                    r_er = bus.rsp_err;
                end
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if (bus.req_ready !== 1'b1) begin
            n_errors++; $display("FAIL reset_ready got %b exp 1", bus.req_ready);
        end
        n_checks++;
        if ({bus.rsp_valid, bus.rsp_err, bus.mem_we, bus.mem_wm} !== 7'd0) begin
            n_errors++;
            $display("FAIL reset_ctrl got %b%b%b%b exp 0", bus.rsp_valid,
                     bus.rsp_err, bus.mem_we, bus.mem_wm);
        end
        n_checks++;
        if ({bus.rsp_rdata, bus.mem_wd, bus.mem_addr} !== 74'd0) begin
            n_errors++;
            $display("FAIL reset_data got %h %h %h exp 0", bus.rsp_rdata,
                     bus.mem_wd, bus.mem_addr);
        end
    endtask

    task automatic test_word();
        run(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
        n_checks++;
        if ({l_wm[1], l_wm[2], l_wm[3], l_wm[4]} !== 16'h1248) begin
            n_errors++;
            $display("FAIL sw_lanes got %h%h%h%h exp 1248",
                     l_wm[1], l_wm[2], l_wm[3], l_wm[4]);
        end
        n_checks++;
        if ({l_we[1], l_we[2], l_we[3], l_we[4], l_we[5]} !== 5'b11110) begin
            n_errors++;
            $display("FAIL sw_we got %b%b%b%b%b exp 11110",
                     l_we[1], l_we[2], l_we[3], l_we[4], l_we[5]);
        end
        n_checks++;
        if (l_addr[1] !== 10'd4 || l_addr[4] !== 10'd4 ||
            l_wd[1] !== 32'hDEADBEEF) begin
            n_errors++;
            $display("FAIL sw_addr got %0d %0d %h exp 4 4 deadbeef",
                     l_addr[1], l_addr[4], l_wd[1]);
        end
        n_checks++;
        if (lat !== 5 || nrsp !== 1 || r_er !== 1'b0 || r_rd !== 32'd0) begin
            n_errors++;
            $display("FAIL sw_rsp got lat %0d n %0d err %b rd %h exp 5 1 0 0",
                     lat, nrsp, r_er, r_rd);
        end
        run(1'b0, 3'b010, 32'h10, 32'd0);
        n_checks++;
        if (lat !== 2 || r_rd !== 32'hDEADBEEF || r_er !== 1'b0 || any_we != 0) begin
            n_errors++;
            $display("FAIL lw got lat %0d rd %h err %b we %0d exp 2 deadbeef 0 0",
                     lat, r_rd, r_er, any_we);
        end
    endtask

    task automatic test_byte();
        run(1'b1, 3'b000, 32'h13, 32'h000000A5);
        n_checks++;
        if (l_wm[1] !== 4'b1000 || l_wd[1][31:24] !== 8'hA5 ||
            any_we != 1 || lat !== 2) begin
            n_errors++;
            $display("FAIL sb got wm %b wd %h we %0d lat %0d exp 1000 a5 1 2",
                     l_wm[1], l_wd[1], any_we, lat);
        end
        run(1'b0, 3'b000, 32'h13, 32'd0);
        n_checks++;
        if (lat !== 2 || r_rd !== 32'hFFFFFFA5) begin
            n_errors++;
            $display("FAIL lb got lat %0d rd %h exp 2 ffffffa5", lat, r_rd);
        end
        run(1'b0, 3'b100, 32'h13, 32'd0);
        n_checks++;
        if (lat !== 2 || r_rd !== 32'h000000A5) begin
            n_errors++;
            $display("FAIL lbu got lat %0d rd %h exp 2 000000a5", lat, r_rd);
        end
    endtask

    task automatic test_half();
        run(1'b1, 3'b010, 32'h10, 32'h80017F00);
        run(1'b0, 3'b001, 32'h12, 32'd0);
        n_checks++;
        if (lat !== 2 || r_rd !== 32'hFFFF8001) begin
            n_errors++;
            $display("FAIL lh_hi got lat %0d rd %h exp 2 ffff8001", lat, r_rd);
        end
        run(1'b0, 3'b101, 32'h12, 32'd0);
        n_checks++;
        if (r_rd !== 32'h00008001) begin
            n_errors++; $display("FAIL lhu_hi got %h exp 00008001", r_rd);
        end
        run(1'b0, 3'b001, 32'h10, 32'd0);
        n_checks++;
        if (r_rd !== 32'h00007F00) begin
            n_errors++; $display("FAIL lh_lo got %h exp 00007f00", r_rd);
        end
        run(1'b1, 3'b001, 32'h16, 32'h0000BEEF);
        n_checks++;
        if (l_wm[1] !== 4'b0100 || l_wm[2] !== 4'b1000 || lat !== 3 ||
            l_addr[1] !== 10'd5 || l_wd[1] !== 32'hBEEF0000) begin
            n_errors++;
            $display("FAIL sh got wm %b %b lat %0d a %0d wd %h exp 0100 1000 3 5 beef0000",
                     l_wm[1], l_wm[2], lat, l_addr[1], l_wd[1]);
        end
    endtask

    task automatic test_misalign();
        run(1'b1, 3'b010, 32'h10, 32'h44332211);
        run(1'b1, 3'b010, 32'h14, 32'h88776655);
        run(1'b0, 3'b010, 32'h11, 32'd0);
`ifdef MISALIGN_SPLIT_EN
        n_checks++;
        if (lat !== 3 || r_rd !== 32'h55443322 || r_er !== 1'b0 ||
            l_addr[1] !== 10'd4 || l_addr[2] !== 10'd5) begin
            n_errors++;
            $display("FAIL lw_split got lat %0d rd %h err %b a %0d %0d exp 3 55443322 0 4 5",
                     lat, r_rd, r_er, l_addr[1], l_addr[2]);
        end
`else
        n_checks++;
        if (lat !== 1 || r_er !== 1'b1 || r_rd !== 32'd0 || any_we != 0) begin
            n_errors++;
            $display("FAIL lw_misal got lat %0d err %b rd %h we %0d exp 1 1 0 0",
                     lat, r_er, r_rd, any_we);
        end
        run(1'b1, 3'b001, 32'h11, 32'h1234);
        n_checks++;
        if (lat !== 1 || r_er !== 1'b1 || any_we != 0) begin
            n_errors++;
            $display("FAIL sh_misal got lat %0d err %b we %0d exp 1 1 0",
                     lat, r_er, any_we);
        end
`endif
    endtask

    task automatic test_illegal();
        run(1'b0, 3'b011, 32'h10, 32'd0);
        n_checks++;
        if (lat !== 1 || r_er !== 1'b1 || r_rd !== 32'd0 || any_we != 0) begin
            n_errors++;
            $display("FAIL ld_f3_011 got lat %0d err %b rd %h we %0d exp 1 1 0 0",
                     lat, r_er, r_rd, any_we);
        end
        run(1'b1, 3'b100, 32'h10, 32'hFFFFFFFF);
        n_checks++;
        if (lat !== 1 || r_er !== 1'b1 || any_we != 0) begin
            n_errors++;
            $display("FAIL st_f3_100 got lat %0d err %b we %0d exp 1 1 0",
                     lat, r_er, any_we);
        end
    endtask

    task automatic test_back_to_back();
        int busy_rdy;
        int rdy6;
        int c1;
        int c2;
        logic [31:0] d2;
        busy_rdy = 0; rdy6 = 0; c1 = 0; c2 = 0; d2 = 32'd0;
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_funct3 = 3'b010;
        bus.req_addr   = 32'h20;
        bus.req_wdata  = 32'h11223344;
        @(posedge clk);
        #1;
        bus.req_we     = 1'b0;
        bus.req_wdata  = 32'hFFFFFFFF;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k <= 5 && bus.req_ready) busy_rdy++;
            if (k == 6) rdy6 = int'(bus.req_ready);
            if (bus.rsp_valid) begin
                if (c1 == 0) c1 = k;
                else if (c2 == 0) begin
                    c2 = k;
                    d2 = bus.rsp_rdata;
                end
            end
            if (k == 7) bus.req_valid = 1'b0;
        end
        n_checks++;
        if (busy_rdy != 0 || rdy6 != 1) begin
            n_errors++;
            $display("FAIL busy_ready got busy %0d rdy6 %0d exp 0 1", busy_rdy, rdy6);
        end
        n_checks++;
        if (c1 != 5 || c2 != 8 || d2 !== 32'h11223344) begin
            n_errors++;
            $display("FAIL b2b_rsp got %0d %0d %h exp 5 8 11223344", c1, c2, d2);
        end
    endtask

    task automatic test_reset_mid_store();
        int stray;
        stray = 0;
        run(1'b1, 3'b010, 32'h30, 32'h00000000);
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_funct3 = 3'b010;
        bus.req_addr   = 32'h30;
        bus.req_wdata  = 32'h12345678;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (bus.mem_wm !== 4'b0010 || bus.mem_we !== 1'b1) begin
            n_errors++;
            $display("FAIL rst_pre got wm %b we %b exp 0010 1", bus.mem_wm, bus.mem_we);
        end
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.mem_we !== 1'b0 || bus.mem_wm !== 4'd0 ||
            bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL rst_abort got we %b wm %b rdy %b rv %b exp 0 0 1 0",
                     bus.mem_we, bus.mem_wm, bus.req_ready, bus.rsp_valid);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (bus.rsp_valid) stray++;
        end
        n_checks++;
        if (stray != 0) begin
            n_errors++; $display("FAIL rst_no_rsp got %0d exp 0", stray);
        end
        run(1'b0, 3'b010, 32'h30, 32'd0);
        n_checks++;
        if (r_rd[7:0] !== 8'h78 || r_rd[31:16] !== 16'h0000) begin
            n_errors++;
            $display("FAIL rst_mem got %h exp ....??78 upper 0000", r_rd);
        end
    endtask

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = 32'd0;
        bus.req_wdata  = 32'd0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_misalign();
        test_illegal();
        test_back_to_back();
        test_reset_mid_store();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
